// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and enables. Optional BNE support via MC_CONTROLLER_BNE_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned SW = 4;

  localparam logic [SW-1:0] FETCH   = 4'd0;
  localparam logic [SW-1:0] DECODE  = 4'd1;
  localparam logic [SW-1:0] MEMADR  = 4'd2;
  localparam logic [SW-1:0] MEMRD   = 4'd3;
  localparam logic [SW-1:0] MEMWB   = 4'd4;
  localparam logic [SW-1:0] MEMWR   = 4'd5;
  localparam logic [SW-1:0] EXECUTE = 4'd6;
  localparam logic [SW-1:0] ALUWB   = 4'd7;
  localparam logic [SW-1:0] BEQEX   = 4'd8;
  localparam logic [SW-1:0] ADDIEX  = 4'd9;
  localparam logic [SW-1:0] ADDIWB  = 4'd10;
  localparam logic [SW-1:0] JEX     = 4'd11;
`ifdef MC_CONTROLLER_BNE_EN
  localparam logic [SW-1:0] BNEEX   = 4'd12;
  localparam logic [5:0]    OP_BNE  = 6'b000101;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_n;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  assign state = state_q;

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    state_n = FETCH;
    case (state_q)
      FETCH:   state_n = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXECUTE;
          OP_BEQ:       state_n = BEQEX;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JEX;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:       state_n = BNEEX;
`endif
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:  state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_n = memready ? MEMWB : MEMRD;
      MEMWB:   state_n = FETCH;
      MEMWR:   state_n = memready ? FETCH : MEMWR;
      EXECUTE: state_n = ALUWB;
      ALUWB:   state_n = FETCH;
      BEQEX:   state_n = FETCH;
      ADDIEX:  state_n = ADDIWB;
      ADDIWB:  state_n = FETCH;
      JEX:     state_n = FETCH;
`ifdef MC_CONTROLLER_BNE_EN
      BNEEX:   state_n = FETCH;
`endif
      default: state_n = FETCH;
    endcase
  end

  // Output decode; reset masks every strobe that could change architectural state
  always_comb begin
    aluop    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:  illegal = 1'b0;
`endif
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:  iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
`ifdef MC_CONTROLLER_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = ~zero;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expectations follow the
// MC_CONTROLLER_BNE_EN setting of the build.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memready;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       pcen;
  logic       illegal;
  logic [3:0] state;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .pcen(pcen), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then let the combinational outputs settle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; memready = 1'b1; op = 6'b000000; zero = 1'b0;
    step(); step();
    settle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_irwrite", 32'(irwrite), 32'd0);
    chk("rst_pcen", 32'(pcen), 32'd0);
    chk("rst_alusrcb", 32'(alusrcb), 32'd1);

    // R-type
    reset = 1'b0; settle();
    chk("r_fetch_state", 32'(state), 32'd0);
    chk("r_fetch_irwrite", 32'(irwrite), 32'd1);
    chk("r_fetch_pcen", 32'(pcen), 32'd1);
    chk("r_fetch_aluop", 32'(aluop), 32'd0);
    step(); settle();
    chk("r_decode_state", 32'(state), 32'd1);
    chk("r_decode_alusrcb", 32'(alusrcb), 32'd3);
    chk("r_decode_illegal", 32'(illegal), 32'd0);
    step(); settle();
    chk("r_exec_state", 32'(state), 32'd6);
    chk("r_exec_aluop", 32'(aluop), 32'd2);
    chk("r_exec_alusrca", 32'(alusrca), 32'd1);
    chk("r_exec_alusrcb", 32'(alusrcb), 32'd0);
    step(); settle();
    chk("r_aluwb_state", 32'(state), 32'd7);
    chk("r_aluwb_regwrite", 32'(regwrite), 32'd1);
    chk("r_aluwb_regdst", 32'(regdst), 32'd1);
    step(); settle();
    chk("r_back_fetch", 32'(state), 32'd0);

    // lw with two stall cycles in MEMRD
    t0 = cyc;
    step(); op = 6'b100011; settle();
    chk("lw_decode", 32'(state), 32'd1);
    step(); settle();
    chk("lw_memadr", 32'(state), 32'd2);
    chk("lw_memadr_alusrcb", 32'(alusrcb), 32'd2);
    memready = 1'b0;
    step(); settle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) memready = 1'b1;
      settle();
      chk("lw_memrd_state", 32'(state), 32'd3);
      chk("lw_memrd_iord", 32'(iord), 32'd1);
      step();
    end
    settle();
    chk("lw_memwb_state", 32'(state), 32'd4);
    chk("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
    chk("lw_memwb_regwrite", 32'(regwrite), 32'd1);
    chk("lw_memwb_regdst", 32'(regdst), 32'd0);
    step(); settle();
    chk("lw_total_cycles", 32'(cyc - t0), 32'd7);
    chk("lw_back_fetch", 32'(state), 32'd0);

    // sw with one FETCH stall
    memready = 1'b0; settle();
    chk("sw_stall_irwrite", 32'(irwrite), 32'd0);
    chk("sw_stall_pcen", 32'(pcen), 32'd0);
    step(); memready = 1'b1; settle();
    chk("sw_fetch_state", 32'(state), 32'd0);
    chk("sw_fetch_irwrite", 32'(irwrite), 32'd1);
    step(); op = 6'b101011; settle();
    chk("sw_decode", 32'(state), 32'd1);
    step(); settle();
    chk("sw_memadr_memwrite", 32'(memwrite), 32'd0);
    step(); settle();
    chk("sw_memwr_state", 32'(state), 32'd5);
    chk("sw_memwr_memwrite", 32'(memwrite), 32'd1);
    chk("sw_memwr_iord", 32'(iord), 32'd1);
    step(); settle();
    chk("sw_after_state", 32'(state), 32'd0);
    chk("sw_after_memwrite", 32'(memwrite), 32'd0);

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      step(); op = 6'b000100; zero = (k == 0); settle();
      step(); settle();
      chk("beq_state", 32'(state), 32'd8);
      chk("beq_aluop", 32'(aluop), 32'd1);
      chk("beq_pcsrc", 32'(pcsrc), 32'd1);
      chk("beq_pcen", 32'(pcen), (k == 0) ? 32'd1 : 32'd0);
      step(); settle();
      chk("beq_back_fetch", 32'(state), 32'd0);
    end

    // bne opcode
    zero = 1'b0;
    step(); op = 6'b000101; settle();
`ifdef MC_CONTROLLER_BNE_EN
    chk("bne_decode_illegal", 32'(illegal), 32'd0);
    step(); settle();
    chk("bne_state", 32'(state), 32'd12);
    chk("bne_pcen", 32'(pcen), 32'd1);
    chk("bne_aluop", 32'(aluop), 32'd1);
    zero = 1'b1; settle();
    chk("bne_pcen_zero", 32'(pcen), 32'd0);
    step(); settle();
    chk("bne_back_fetch", 32'(state), 32'd0);
`else
    chk("bne_decode_illegal", 32'(illegal), 32'd1);
    step(); settle();
    chk("bne_illegal_fetch", 32'(state), 32'd0);
    chk("bne_illegal_drop", 32'(illegal), 32'd0);
`endif

    // reset while stalled in MEMWR
    step(); op = 6'b101011; settle();
    step(); settle();
    memready = 1'b0;
    step(); settle();
    chk("rw_memwr_state", 32'(state), 32'd5);
    chk("rw_memwr_memwrite", 32'(memwrite), 32'd1);
    reset = 1'b1; settle();
    chk("rw_reset_memwrite", 32'(memwrite), 32'd0);
    chk("rw_reset_iord", 32'(iord), 32'd1);
    step(); settle();
    chk("rw_after_state", 32'(state), 32'd0);
    reset = 1'b0; memready = 1'b1; settle();

    // jump after reset
    t0 = cyc;
    step(); op = 6'b000010; settle();
    step(); settle();
    chk("j_state", 32'(state), 32'd11);
    chk("j_pcsrc", 32'(pcsrc), 32'd2);
    chk("j_pcen", 32'(pcen), 32'd1);
    step(); settle();
    chk("j_cycles", 32'(cyc - t0), 32'd3);
    chk("j_back_fetch", 32'(state), 32'd0);

    // illegal opcode takes two cycles
    step(); op = 6'b111111; settle();
    chk("ill_pulse", 32'(illegal), 32'd1);
    step(); settle();
    chk("ill_fetch", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS main control FSM: the producer side of the `aluop` encoding that the ALU decoder consumes. It sequences each instruction through fetch, decode, execute, memory and writeback steps. Per state, it drives the datapath mux selects, the register, IR, PC and memory write enables, and the 2-bit `aluop` class. It sits in the controller beside the ALU decoder and takes `op` from the instruction register and `zero` from the ALU.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  opcode, instr[31:26], from the IR
- zero  input  1  ALU result-zero flag
- memready  input  1  memory access completes this cycle
- aluop  output  2  00 add, 01 sub, 10 use funct
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  output  1  IR load enable
- memwrite  output  1  memory write strobe
- regwrite  output  1  register file write enable
- regdst  output  1  0 = rt, 1 = rd
- memtoreg  output  1  0 = ALUOut, 1 = Data
- pcen  output  1  PC load: pcwrite | (branch & branch condition)
- illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12. Codes 13–15 are unused and go to FETCH.
- Outputs are Moore-decoded from `state`. Exceptions: `irwrite`/`pcen` in FETCH, and `pcen` in branch states. Any output not listed for a state is 0.
- FETCH: `alusrcb`=01, `aluop`=00. When `memready`=1: `irwrite`=1, `pcen`=1, go to DECODE. Otherwise stay, with `irwrite`=`pcen`=0.
- DECODE: `alusrcb`=11, `aluop`=00. Next state by `op`:
  - 100011 / 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - 000101 → BNEEX (BNE_EN only)
  - anything else → FETCH, with `illegal`=1 for this cycle
- MEMADR: `alusrca`=1, `alusrcb`=10. Go to MEMRD if `op`=100011, else MEMWR.
- MEMRD: `iord`=1. Stay until `memready`, then MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0 → FETCH.
- MEMWR: `iord`=1, `memwrite`=1, held for every cycle in the state. Stay until `memready`, then FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10 → ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1 → FETCH.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `pcen`=`zero` → FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10 → ADDIWB.
- ADDIWB: `regwrite`=1, `regdst`=0 → FETCH.
- JEX: `pcsrc`=10, `pcen`=1 → FETCH.

## Timing
- Reset: when `reset`=1 at a rising edge, `state` ← FETCH. While `reset`=1, `irwrite`, `pcen`, `memwrite`, `regwrite` and `illegal` are forced to 0. All other outputs decode from the current state.
- Reset wins over any pending transition, including mid-MEMWR and mid-stall.
- Cycle counts with `memready` tied to 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - bne: 3
  - j: 3
  - illegal: 2
- Each cycle `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. No timeout.
- `memready` is ignored in every other state.
- `op` is sampled in DECODE and MEMADR only; the IR is stable there.

## Configuration
- `MC_CONTROLLER_BNE_EN` defined:
  - opcode 000101 decodes to BNEEX.
  - BNEEX drives the same outputs as BEQEX, except `pcen` = ~`zero`.
- Not defined:
  - 000101 is illegal.
  - BNEEX is unreachable; state code 12 goes to FETCH like the other unused codes.

## Test plan
- Reset, then release with `memready`=1 and `op`=000000. Required: states FETCH→DECODE→EXECUTE→ALUWB→FETCH. `aluop`=10 in EXECUTE; `regwrite`=1 and `regdst`=1 in ALUWB.
- lw (100011) with `memready` low for 2 cycles in MEMRD. Required: MEMRD held for 3 cycles with `iord`=1, then MEMWB with `memtoreg`=1 and `regwrite`=1; 7 cycles total.
- sw (101011) with `memready`=0 for one cycle in FETCH. Required: no `irwrite`/`pcen` in the stalled cycle. `memwrite`=1 for exactly one cycle in MEMWR.
- beq with `zero`=1, then with `zero`=0. Required: `aluop`=01 and `pcsrc`=01 in BEQEX; `pcen`=1 in the first case, 0 in the second.
- `op`=000101 in both builds:
  - With the macro: BNEEX, with `pcen`=1 when `zero`=0.
  - Without: `illegal`=1 for one cycle, then FETCH.
- `reset` asserted while in MEMWR. Required: `memwrite` drops to 0 in the same cycle; `state`=0 after the edge; j (000010) then completes in 3 cycles with `pcsrc`=10.
